// File: rtl/bitstream_decoder_array.sv
// bitstream_decoder_array: windowed up/down counting of stochastic p/m bitstream pairs into signed results.
// Optional BITSTREAM_DECODER_AUTORESTART_EN selects back-to-back windows with a sticky overrun flag.
module bitstream_decoder_array #(
    parameter int NUM_ELEMENTS = 1,
    parameter int WINDOW_LOG2  = 8,
    localparam int ACC_W       = WINDOW_LOG2 + 2
) (
    input  logic                            CLK,
    input  logic                            RST,
    input  logic                            start,
    input  logic                            clear,
    input  logic [NUM_ELEMENTS-1:0]         in_p,
    input  logic [NUM_ELEMENTS-1:0]         in_m,
    output logic [NUM_ELEMENTS*ACC_W-1:0]   out_value,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic                            busy,
    output logic                            overrun
);
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t                                 state_q, state_d;
    logic [WINDOW_LOG2-1:0]                 cnt_q, cnt_d;
    logic [NUM_ELEMENTS-1:0][ACC_W-1:0]     acc_q, acc_d, sum;
    logic [NUM_ELEMENTS*ACC_W-1:0]          out_value_q, out_value_d;
    logic                                   out_valid_q, out_valid_d;
    logic                                   busy_q, busy_d;
    logic                                   overrun_q, overrun_d;
    logic                                   last, handshake;

    assign last      = cnt_q == '1;
    assign handshake = out_valid_q && out_ready;

    // Two's-complement add of +1 / -1 / 0 per element; wraps cleanly at ACC_W.
    always_comb begin
        sum = acc_q;
        for (int i = 0; i < NUM_ELEMENTS; i++)
            sum[i] = acc_q[i] + ((in_p[i] & ~in_m[i]) ? ACC_W'(1) :
                                 (in_m[i] & ~in_p[i]) ? {ACC_W{1'b1}} : '0);
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        out_value_d = out_value_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        overrun_d   = overrun_q;
        if (clear) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            busy_d      = 1'b0;
            acc_d       = '0;
            cnt_d       = '0;
        end else begin
            unique case (state_q)
                IDLE: if (start) begin
                    state_d = ACCUM;
                    acc_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end
                ACCUM: begin
                    cnt_d = cnt_q + 1'b1;
                    acc_d = last ? '0 : sum;
`ifdef BITSTREAM_DECODER_AUTORESTART_EN
                    if (handshake) out_valid_d = 1'b0;
                    // A pending unaccepted result wins; the new one is dropped.
                    if (last) begin
                        if (out_valid_q && !out_ready) overrun_d = 1'b1;
                        else begin
                            out_value_d = sum;
                            out_valid_d = 1'b1;
                        end
                    end
`else
                    if (last) begin
                        out_value_d = sum;
                        out_valid_d = 1'b1;
                        busy_d      = 1'b0;
                        state_d     = DONE;
                    end
`endif
                end
                DONE: if (handshake) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            out_value_q <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            out_value_q <= out_value_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            overrun_q   <= overrun_d;
        end
    end

    assign out_value = out_value_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign overrun   = overrun_q;
endmodule

// File: tb/tb_bitstream_decoder_array.sv
// tb_bitstream_decoder_array: directed checks of the decoder with two elements and an 8-cycle window.
module tb_bitstream_decoder_array;
    localparam int N = 2;
    localparam int W = 3;
    localparam int A = W + 2;

    logic           CLK = 1'b0;
    logic           RST = 1'b1;
    logic           start = 1'b0, clear = 1'b0, out_ready = 1'b0;
    logic [N-1:0]   in_p = '0, in_m = '0;
    logic [N*A-1:0] out_value;
    logic           out_valid, busy, overrun;
    int             n_tests = 0, n_fail = 0;
    logic [7:0]     p0 = 8'b0011_1111;
    logic [7:0]     m0 = 8'b0100_0011;

    bitstream_decoder_array #(.NUM_ELEMENTS(N), .WINDOW_LOG2(W)) dut (
        .CLK(CLK), .RST(RST), .start(start), .clear(clear), .in_p(in_p), .in_m(in_m),
        .out_value(out_value), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .overrun(overrun)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    function automatic logic [A-1:0] ev(input int i);
        return out_value[i*A +: A];
    endfunction

    function automatic logic [A-1:0] sv(input int v);
        return A'(v);
    endfunction

    initial begin
        tick(2);
        check("rst_value", 32'(out_value), 0);
        check("rst_valid", 32'(out_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_overrun", 32'(overrun), 0);
        RST = 1'b0;
        tick();

`ifndef BITSTREAM_DECODER_AUTORESTART_EN
        // Saturating +8 / -8 window, held while consumer stalls
        in_p = 2'b01; in_m = 2'b10; start = 1'b1;
        tick();
        start = 1'b0;
        check("t2_busy", 32'(busy), 1);
        tick(7);
        check("t2_early_valid", 32'(out_valid), 0);
        tick();
        check("t2_valid", 32'(out_valid), 1);
        check("t2_busy_done", 32'(busy), 0);
        check("t2_e0", 32'(ev(0)), 32'(sv(8)));
        check("t2_e1", 32'(ev(1)), 32'(sv(-8)));
        tick(5);
        check("t2_hold_valid", 32'(out_valid), 1);
        check("t2_hold_e1", 32'(ev(1)), 32'(sv(-8)));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("t2_drop", 32'(out_valid), 0);

        // Mixed stream: elem0 nets +3, elem1 always both -> 0
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int s = 0; s < 8; s++) begin
            in_p = {1'b1, p0[s]};
            in_m = {1'b1, m0[s]};
            tick();
        end
        check("t3_valid", 32'(out_valid), 1);
        check("t3_e0", 32'(ev(0)), 32'(sv(3)));
        check("t3_e1", 32'(ev(1)), 32'(sv(0)));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // start held high through ACCUM and DONE
        in_p = 2'b01; in_m = 2'b00; start = 1'b1;
        tick(8);
        check("t4_early_valid", 32'(out_valid), 0);
        tick();
        check("t4_valid", 32'(out_valid), 1);
        check("t4_e0", 32'(ev(0)), 32'(sv(8)));
        check("t4_e1", 32'(ev(1)), 32'(sv(0)));
        tick(2);
        check("t4_done_busy", 32'(busy), 0);
        check("t4_done_valid", 32'(out_valid), 1);
        start = 1'b0; out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tick();
        check("t4_idle_busy", 32'(busy), 0);

        // clear on the 4th sample edge aborts the window
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(3);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("t5_busy", 32'(busy), 0);
        check("t5_valid", 32'(out_valid), 0);
        check("t5_keep_value", 32'(ev(0)), 32'(sv(8)));
        tick(10);
        check("t5_no_valid", 32'(out_valid), 0);
        in_p = 2'b00; in_m = 2'b11; start = 1'b1; out_ready = 1'b1;
        tick();
        start = 1'b0;
        tick(7);
        check("t5_restart_early", 32'(out_valid), 0);
        tick();
        check("t5_restart_valid", 32'(out_valid), 1);
        check("t5_restart_e0", 32'(ev(0)), 32'(sv(-8)));
        check("t5_restart_e1", 32'(ev(1)), 32'(sv(-8)));
        tick();
        check("t5_zero_cycle_accept", 32'(out_valid), 0);
        out_ready = 1'b0;
        check("t5_overrun_tied", 32'(overrun), 0);
`else
        // Continuous mode: stalled consumer loses the second window
        in_p = 2'b01; in_m = 2'b10; start = 1'b1;
        tick();
        start = 1'b0;
        tick(8);
        check("t6_valid1", 32'(out_valid), 1);
        check("t6_e0_1", 32'(ev(0)), 32'(sv(8)));
        check("t6_busy", 32'(busy), 1);
        in_p = 2'b00; in_m = 2'b00;
        tick(8);
        check("t6_overrun", 32'(overrun), 1);
        check("t6_kept_e0", 32'(ev(0)), 32'(sv(8)));
        check("t6_kept_e1", 32'(ev(1)), 32'(sv(-8)));
        out_ready = 1'b1;
        tick();
        check("t6_accept", 32'(out_valid), 0);
        tick(7);
        check("t6_valid2", 32'(out_valid), 1);
        check("t6_e0_2", 32'(ev(0)), 32'(sv(0)));
        tick();
        check("t6_accept2", 32'(out_valid), 0);
        tick(7);
        check("t6_valid3", 32'(out_valid), 1);
        check("t6_sticky", 32'(overrun), 1);
        clear = 1'b1; out_ready = 1'b0;
        tick();
        clear = 1'b0;
        check("t6_clear_busy", 32'(busy), 0);
        check("t6_clear_overrun", 32'(overrun), 1);
`endif

        // Async reset mid-window discards everything
        in_p = 2'b01; in_m = 2'b00; start = 1'b1;
        tick();
        start = 1'b0;
        tick(3);
        #2 RST = 1'b1;
        #1;
        check("t1_rst_value", 32'(out_value), 0);
        check("t1_rst_busy", 32'(busy), 0);
        check("t1_rst_overrun", 32'(overrun), 0);
        #1 RST = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (out_valid !== 1'b0 || busy !== 1'b0) check("t1_quiet", {30'd0, out_valid, busy}, 0);
        end
        check("t1_quiet_end", {30'd0, out_valid, busy}, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
